twiddle_addr_gen: RTL

- Drives the twiddle-number side of the 1/8-table twiddle converter for one R2²SDF stage pair.
- Counts valid samples within an N-point frame (N = 2^LOG_N) and issues the twiddle exponent for each sample in units of 2π/N.
- The converter reduces this exponent to the 1/8-table address and reconstructs the value.
- Exponents are built by per-quadrant accumulation; the block contains no multiplier.

---
 rtl/twiddle_addr_gen.sv | 78 +++++++
 1 files changed

// File: rtl/twiddle_addr_gen.sv
// rtl/twiddle_addr_gen.sv - twiddle exponent generator for one R2^2 SDF stage pair
module twiddle_addr_gen #(
    parameter int LOG_N = 6,
    parameter bit AG_FF = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic             di_sync,
    output logic             tw_en,
    output logic [LOG_N-1:0] tw_addr,
    output logic [1:0]       tw_quad,
    output logic             tw_last
);

    localparam int P_W = LOG_N - 2;

    logic [LOG_N-1:0] n_q;
    logic [LOG_N-1:0] acc_q;
    logic [LOG_N-1:0] n_cur;
    logic [LOG_N-1:0] e_cur;
    logic [LOG_N-1:0] step_cur;
    logic [1:0]       q_cur;
    logic [P_W-1:0]   p_cur;
    logic             last_cur;

    // A sync sample is forced to index 0; the per-quadrant step S(q) = {0,2,1,3}
    // is just q with its two bits swapped, so no multiplier or table is needed.
    always_comb begin
        n_cur    = di_sync ? '0 : n_q;
        q_cur    = n_cur[LOG_N-1 -: 2];
        p_cur    = n_cur[P_W-1:0];
        step_cur = {{(LOG_N-2){1'b0}}, q_cur[0], q_cur[1]};
        if (p_cur == '0) begin
            e_cur = '0;
        end else begin
            e_cur = acc_q + step_cur;
        end
        last_cur = &n_cur;
    end

    // Storing e at p = 0 also clears the accumulator at each quadrant boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_q   <= '0;
            acc_q <= '0;
        end else if (di_en) begin
            n_q   <= n_cur + LOG_N'(1);
            acc_q <= e_cur;
        end
    end

    generate
        if (AG_FF) begin : g_reg_out
            always_ff @(posedge clock) begin
                if (reset) begin
                    tw_en   <= 1'b0;
                    tw_addr <= '0;
                    tw_quad <= 2'b00;
                    tw_last <= 1'b0;
                end else begin
                    tw_en <= di_en;
                    if (di_en) begin
                        tw_addr <= e_cur;
                        tw_quad <= q_cur;
                        tw_last <= last_cur;
                    end
                end
            end
        end else begin : g_comb_out
            assign tw_en   = di_en & ~reset;
            assign tw_addr = e_cur;
            assign tw_quad = q_cur;
            assign tw_last = last_cur;
        end
    endgenerate

endmodule
